// File: rtl/l1_mem_arbiter_if.sv
// Bundles the icache, dcache and pmem sides of the L1 memory arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
`timescale 1ns/1ps
interface l1_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_read, i_addr,
    output i_rdata, i_resp,
    input  d_read, d_write, d_addr, d_wdata,
    output d_rdata, d_resp,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output i_read, i_addr,
    input  i_rdata, i_resp,
    output d_read, d_write, d_addr, d_wdata,
    input  d_rdata, d_resp,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/l1_mem_arbiter.sv
// Shares one pmem port between the L1 icache (read-only) and dcache (read/write).
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is dcache priority.
`timescale 1ns/1ps
module l1_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  l1_mem_arbiter_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RECOVER = 2'd3
  } state_t;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } cmd_t;

  state_t r_state;
  cmd_t   r_cmd;

  logic w_d_req;
  logic w_any_req;
  logic w_grant_d;
  logic w_live_i;
  logic w_live_d;

  assign w_d_req   = bus.d_read | bus.d_write;
  assign w_any_req = w_d_req | bus.i_read;

`ifdef ARB_ROUND_ROBIN_EN
  // 0 = icache served last, 1 = dcache served last
  logic r_last_d;
  assign w_grant_d = w_d_req & (~bus.i_read | ~r_last_d);
`else
  assign w_grant_d = w_d_req;
`endif

  // Grant in IDLE latches the winner's command; the pmem response closes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cmd   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_d <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            if (w_grant_d) begin
              r_state     <= SERVE_D;
              r_cmd.wr    <= bus.d_write;
              r_cmd.rd    <= ~bus.d_write;
              r_cmd.addr  <= bus.d_addr;
              r_cmd.wdata <= bus.d_write ? bus.d_wdata : '0;
            end else begin
              r_state     <= SERVE_I;
              r_cmd.wr    <= 1'b0;
              r_cmd.rd    <= 1'b1;
              r_cmd.addr  <= bus.i_addr;
              r_cmd.wdata <= '0;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (bus.mem_resp) begin
            r_state <= RECOVER;
            r_cmd   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_d <= (r_state == SERVE_D);
`endif
          end
        end
        RECOVER: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // A reset cycle suppresses any response even if pmem answers in it.
  assign w_live_i = (r_state == SERVE_I) & ~rst;
  assign w_live_d = (r_state == SERVE_D) & ~rst;

  assign bus.i_resp  = w_live_i & bus.mem_resp;
  assign bus.d_resp  = w_live_d & bus.mem_resp;
  assign bus.i_rdata = bus.i_resp ? bus.mem_rdata : '0;
  assign bus.d_rdata = bus.d_resp ? bus.mem_rdata : '0;

  assign bus.mem_read  = r_cmd.rd;
  assign bus.mem_write = r_cmd.wr;
  assign bus.mem_addr  = r_cmd.addr;
  assign bus.mem_wdata = r_cmd.wdata;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed plus randomized bench for l1_mem_arbiter against a transaction-level model.
`timescale 1ns/1ps
module tb_l1_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic rst;

  l1_mem_arbiter_if #(.ADDR_W(32), .LINE_W(256)) bus ();

  l1_mem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chka(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkl(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  // Transaction-level model: who owns the port, what command it issued,
  // and how many quiet cycles remain before the next arbitration.
  int          m_owner = 0;   // 0 none, 1 icache, 2 dcache
  logic [31:0] m_addr;
  logic        m_wr;
  logic [255:0] m_wdata;
  int          m_quiet = 0;
  bit          m_last_d = 1'b0;
  bit          m_valid = 1'b0;
  bit          d_wins;
  logic        e_ir, e_dr, e_busy;

  always @(negedge clk) begin
    if (m_valid) begin
      e_busy = (m_owner != 0);
      e_ir   = (m_owner == 1) && bus.mem_resp && !rst;
      e_dr   = (m_owner == 2) && bus.mem_resp && !rst;
      chk1("mdl_mem_read",  bus.mem_read,  e_busy && !m_wr);
      chk1("mdl_mem_write", bus.mem_write, e_busy && m_wr);
      chka("mdl_mem_addr",  bus.mem_addr,  e_busy ? m_addr : 32'h0);
      if (!e_busy || m_wr)
        chkl("mdl_mem_wdata", bus.mem_wdata, e_busy ? m_wdata : 256'h0);
      chk1("mdl_i_resp",  bus.i_resp, e_ir);
      chk1("mdl_d_resp",  bus.d_resp, e_dr);
      chkl("mdl_i_rdata", bus.i_rdata, e_ir ? bus.mem_rdata : 256'h0);
      chkl("mdl_d_rdata", bus.d_rdata, e_dr ? bus.mem_rdata : 256'h0);
    end
    if (rst) begin
      m_owner  = 0;
      m_quiet  = 0;
      m_last_d = 1'b0;
      m_valid  = 1'b1;
    end else if (m_owner != 0) begin
      if (bus.mem_resp) begin
        m_last_d = (m_owner == 2);
        m_owner  = 0;
        m_quiet  = 1;
      end
    end else if (m_quiet > 0) begin
      m_quiet = m_quiet - 1;
    end else if (bus.i_read || bus.d_read || bus.d_write) begin
      d_wins  = (bus.d_read || bus.d_write) && (!bus.i_read || !RR || !m_last_d);
      m_owner = d_wins ? 2 : 1;
      m_wr    = d_wins && bus.d_write;
      m_addr  = d_wins ? bus.d_addr : bus.i_addr;
      m_wdata = bus.d_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_read = 1'b0; bus.i_addr = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_resp = 1'b0;
  endtask

  logic [255:0] line_a, line_b, line_c;
  logic [255:0] a5_line;
  int  lat = 2;
  bit  i_got, d_got;
  int  k;

  task automatic drive_random();
    rst = ($urandom_range(0, 299) == 0);
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = rand_line();
    if (bus.mem_read || bus.mem_write) begin
      if (lat == 0) begin
        bus.mem_resp = 1'b1;
        lat = $urandom_range(0, 5);
      end else lat = lat - 1;
    end else if ($urandom_range(0, 15) == 0) begin
      bus.mem_resp = 1'b1;
    end
    if (i_got) bus.i_read = 1'b0;
    else if (bus.i_read && $urandom_range(0, 59) == 0) bus.i_read = 1'b0;
    else if (!bus.i_read && $urandom_range(0, 3) == 0) begin
      bus.i_read = 1'b1;
      bus.i_addr = $urandom() & 32'hFFFF_FFE0;
    end
    if (d_got) begin
      bus.d_read = 1'b0; bus.d_write = 1'b0;
    end else if ((bus.d_read || bus.d_write) && $urandom_range(0, 59) == 0) begin
      bus.d_read = 1'b0; bus.d_write = 1'b0;
    end else if (!(bus.d_read || bus.d_write) && $urandom_range(0, 3) == 0) begin
      k = $urandom_range(0, 4);
      bus.d_read  = (k < 2) || (k == 4);
      bus.d_write = (k >= 2);
      bus.d_addr  = $urandom() & 32'hFFFF_FFE0;
      bus.d_wdata = rand_line();
    end
  endtask

  initial begin
    line_a  = rand_line();
    line_b  = rand_line();
    line_c  = rand_line();
    a5_line = {32{8'hA5}};
    rst = 1'b1;
    clear_inputs();
    repeat (3) tick();
    chk1("rst_mem_read",  bus.mem_read,  1'b0);
    chk1("rst_mem_write", bus.mem_write, 1'b0);
    chka("rst_mem_addr",  bus.mem_addr,  32'h0);
    chk1("rst_i_resp",    bus.i_resp,    1'b0);
    chk1("rst_d_resp",    bus.d_resp,    1'b0);
    rst = 1'b0;

    // single icache read, response after 4 command cycles
    bus.i_read = 1'b1; bus.i_addr = 32'h0000_1000;
    tick();
    chk1("t1_mem_read_c1", bus.mem_read, 1'b1);
    chka("t1_mem_addr",    bus.mem_addr, 32'h0000_1000);
    tick(); tick(); tick();
    bus.mem_resp = 1'b1; bus.mem_rdata = line_a; #1;
    chk1("t1_i_resp",  bus.i_resp,  1'b1);
    chkl("t1_i_rdata", bus.i_rdata, line_a);
    chk1("t1_d_resp",  bus.d_resp,  1'b0);
    tick();
    bus.mem_resp = 1'b0; bus.i_read = 1'b0; #1;
    chk1("t1_recover_read", bus.mem_read, 1'b0);
    chk1("t1_i_resp_off",   bus.i_resp,   1'b0);

    // dcache writeback
    tick();
    bus.d_write = 1'b1; bus.d_addr = 32'h8000_0040; bus.d_wdata = a5_line;
    tick();
    chk1("t2_mem_write", bus.mem_write, 1'b1);
    chk1("t2_mem_read",  bus.mem_read,  1'b0);
    chkl("t2_mem_wdata", bus.mem_wdata, a5_line);
    chka("t2_mem_addr",  bus.mem_addr,  32'h8000_0040);
    tick();
    bus.mem_resp = 1'b1; bus.mem_rdata = line_b; #1;
    chk1("t2_d_resp", bus.d_resp, 1'b1);
    chk1("t2_i_resp", bus.i_resp, 1'b0);
    tick();
    bus.mem_resp = 1'b0; bus.d_write = 1'b0; #1;
    chk1("t2_d_resp_pulse", bus.d_resp,    1'b0);
    chk1("t2_recover",      bus.mem_write, 1'b0);
    tick();

    // simultaneous requests; dcache re-requests during the wait
    bus.i_read = 1'b1; bus.i_addr = 32'h0000_2000;
    bus.d_read = 1'b1; bus.d_addr = 32'h0000_3000;
    tick();
    chk1("t3_first_read", bus.mem_read, 1'b1);
    chka("t3_first_d",    bus.mem_addr, 32'h0000_3000);
    bus.mem_resp = 1'b1; bus.mem_rdata = line_c; #1;
    chk1("t3_first_dresp", bus.d_resp,  1'b1);
    chk1("t3_loser_iresp", bus.i_resp,  1'b0);
    chkl("t3_loser_rdata", bus.i_rdata, 256'h0);
    tick();
    bus.mem_resp = 1'b0; bus.d_read = 1'b0;
    chk1("t3_gap1", bus.mem_read, 1'b0);
    tick();
    bus.d_read = 1'b1; bus.d_addr = 32'h0000_3100;
    chk1("t3_gap2", bus.mem_read, 1'b0);
    tick();
    chk1("t3_second_read", bus.mem_read, 1'b1);
    chka("t3_second_addr", bus.mem_addr, RR ? 32'h0000_2000 : 32'h0000_3100);
    bus.mem_resp = 1'b1; #1;
    chk1("t3_second_iresp", bus.i_resp, RR);
    chk1("t3_second_dresp", bus.d_resp, !RR);
    tick();
    bus.mem_resp = 1'b0;
    if (RR) bus.i_read = 1'b0; else bus.d_read = 1'b0;
    tick(); tick();
    chk1("t3_third_read", bus.mem_read, 1'b1);
    chka("t3_third_addr", bus.mem_addr, RR ? 32'h0000_3100 : 32'h0000_2000);
    bus.mem_resp = 1'b1; #1;
    chk1("t3_third_resp", RR ? bus.d_resp : bus.i_resp, 1'b1);
    tick();
    bus.mem_resp = 1'b0; bus.i_read = 1'b0; bus.d_read = 1'b0;
    tick();

    // read and write together behave as a write
    bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_addr = 32'h0000_0040; bus.d_wdata = line_b;
    tick();
    for (int c = 0; c < 3; c++) begin
      chk1("t4_write", bus.mem_write, 1'b1);
      chk1("t4_read",  bus.mem_read,  1'b0);
      tick();
    end
    bus.mem_resp = 1'b1; #1;
    chk1("t4_d_resp", bus.d_resp, 1'b1);
    tick();
    bus.mem_resp = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    tick();

    // reset two cycles into an icache transaction
    bus.i_read = 1'b1; bus.i_addr = 32'h0000_5000;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk1("t5_read_dropped", bus.mem_read, 1'b0);
    chk1("t5_no_resp",      bus.i_resp,   1'b0);
    tick();
    chk1("t5_regrant",      bus.mem_read, 1'b1);
    chka("t5_regrant_addr", bus.mem_addr, 32'h0000_5000);
    bus.mem_resp = 1'b1; #1;
    chk1("t5_i_resp", bus.i_resp, 1'b1);
    tick();
    bus.mem_resp = 1'b0; bus.i_read = 1'b0;
    tick();

    // spurious pmem response while idle
    bus.mem_resp = 1'b1; #1;
    chk1("t6_i_resp", bus.i_resp, 1'b0);
    chk1("t6_d_resp", bus.d_resp, 1'b0);
    tick();
    bus.mem_resp = 1'b0;
    bus.i_read = 1'b1; bus.i_addr = 32'h0000_6000;
    chk1("t6_idle_read",  bus.mem_read,  1'b0);
    chk1("t6_idle_write", bus.mem_write, 1'b0);
    tick();
    chk1("t6_grant", bus.mem_read, 1'b1);
    bus.mem_resp = 1'b1; #1;
    tick();
    bus.mem_resp = 1'b0; bus.i_read = 1'b0;
    tick();

    // randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      i_got = bus.i_resp;
      d_got = bus.d_resp;
      @(posedge clk);
      #1;
      drive_random();
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_inputs();
    repeat (12) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
